// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// State encodings, master indices and the default timeout length.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall watchdog for the granted Wishbone cycle.
// Emits a one-cycle error pulse after TIMEOUT_CYCLES strobed cycles without ack.
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic err_o
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign err_o = stb_i & ~ack_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clr_i || ack_i || !stb_i || err_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter, registered round-robin grant.
// Define WB_ARB_TIMEOUT_EN to add the stalled-slave bus-error watchdog.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [ADDR_W-1:0]     m0_wb_adr_i,
  input  logic                  m0_wb_cyc_i,
  input  logic                  m0_wb_stb_i,
  output logic [DATA_W-1:0]     m0_wb_dat_o,
  output logic                  m0_wb_ack_o,
  output logic                  m0_wb_err_o,
  input  logic [ADDR_W-1:0]     m1_wb_adr_i,
  input  logic [DATA_W-1:0]     m1_wb_dat_i,
  input  logic                  m1_wb_cyc_i,
  input  logic                  m1_wb_stb_i,
  input  logic                  m1_wb_we_i,
  input  logic [DATA_W/8-1:0]   m1_wb_sel_i,
  output logic [DATA_W-1:0]     m1_wb_dat_o,
  output logic                  m1_wb_ack_o,
  output logic                  m1_wb_err_o,
  output logic [ADDR_W-1:0]     s_wb_adr_o,
  output logic [DATA_W-1:0]     s_wb_dat_o,
  input  logic [DATA_W-1:0]     s_wb_dat_i,
  output logic                  s_wb_cyc_o,
  output logic                  s_wb_stb_o,
  output logic                  s_wb_we_o,
  output logic [DATA_W/8-1:0]   s_wb_sel_o,
  input  logic                  s_wb_ack_i
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       g0, g1;
  logic       cyc_g, stb_g;
  logic       to_err;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GNT0: if (!m0_wb_cyc_i) state_d = m1_wb_cyc_i ? GNT1 : IDLE;
      GNT1: if (!m1_wb_cyc_i) state_d = m0_wb_cyc_i ? GNT0 : IDLE;
      default: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          state_d = (last_q == M1) ? GNT0 : GNT1;
        end else if (m0_wb_cyc_i) begin
          state_d = GNT0;
        end else if (m1_wb_cyc_i) begin
          state_d = GNT1;
        end
      end
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_d == GNT0) last_d = M0;
    if (state_d == GNT1) last_d = M1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= M1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign g0    = (state_q == GNT0);
  assign g1    = (state_q == GNT1);
  assign cyc_g = (g0 & m0_wb_cyc_i) | (g1 & m1_wb_cyc_i);
  assign stb_g = (g0 & m0_wb_cyc_i & m0_wb_stb_i)
               | (g1 & m1_wb_cyc_i & m1_wb_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .clr_i (state_d != state_q),
    .stb_i (stb_g),
    .ack_i (s_wb_ack_i),
    .err_o (to_err)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 1);
  assign to_err         = 1'b0;
`endif

  // An expiring watchdog pulls the slave off the bus for that cycle.
  assign s_wb_cyc_o = cyc_g & ~to_err;
  assign s_wb_stb_o = stb_g & ~to_err;

  always_comb begin
    s_wb_adr_o = '0;
    s_wb_dat_o = '0;
    s_wb_sel_o = '0;
    s_wb_we_o  = 1'b0;
    unique case (1'b1)
      g0: begin
        s_wb_adr_o = m0_wb_adr_i;
        s_wb_sel_o = '1;
      end
      g1: begin
        s_wb_adr_o = m1_wb_adr_i;
        s_wb_dat_o = m1_wb_dat_i;
        s_wb_sel_o = m1_wb_sel_i;
        s_wb_we_o  = m1_wb_we_i;
      end
      default: ;
    endcase
  end

  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;
  assign m0_wb_ack_o = g0 & s_wb_cyc_o & s_wb_ack_i;
  assign m1_wb_ack_o = g1 & s_wb_cyc_o & s_wb_ack_i;
  assign m0_wb_err_o = g0 & to_err;
  assign m1_wb_err_o = g1 & to_err;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2.
// Directed scenarios plus a randomized run against a grant-ownership model.
module tb_wb_arbiter2;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] m0_adr = '0;
  logic          m0_cyc = 1'b0, m0_stb = 1'b0;
  logic [DW-1:0] m0_dat;
  logic          m0_ack, m0_err;
  logic [AW-1:0] m1_adr = '0;
  logic [DW-1:0] m1_wdat = '0;
  logic          m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [SW-1:0] m1_sel = '0;
  logic [DW-1:0] m1_dat;
  logic          m1_ack, m1_err;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat;
  logic [DW-1:0] s_rdat = '0;
  logic          s_cyc, s_stb, s_we;
  logic [SW-1:0] s_sel;
  logic          s_ack = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  wb_arbiter2 #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .m0_wb_adr_i (m0_adr),
    .m0_wb_cyc_i (m0_cyc),
    .m0_wb_stb_i (m0_stb),
    .m0_wb_dat_o (m0_dat),
    .m0_wb_ack_o (m0_ack),
    .m0_wb_err_o (m0_err),
    .m1_wb_adr_i (m1_adr),
    .m1_wb_dat_i (m1_wdat),
    .m1_wb_cyc_i (m1_cyc),
    .m1_wb_stb_i (m1_stb),
    .m1_wb_we_i  (m1_we),
    .m1_wb_sel_i (m1_sel),
    .m1_wb_dat_o (m1_dat),
    .m1_wb_ack_o (m1_ack),
    .m1_wb_err_o (m1_err),
    .s_wb_adr_o  (s_adr),
    .s_wb_dat_o  (s_wdat),
    .s_wb_dat_i  (s_rdat),
    .s_wb_cyc_o  (s_cyc),
    .s_wb_stb_o  (s_stb),
    .s_wb_we_o   (s_we),
    .s_wb_sel_o  (s_sel),
    .s_wb_ack_i  (s_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    s_ack  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h44;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    s_ack = 1'b1; s_rdat = 32'hA5A5_0F0F;
    nxt();
    smp();
    n_chk++;
    if ({s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel} !== '0) begin
      n_fail++;
      $display("FAIL reset_slave: got %b/%b/%b %h %h %h want all 0",
               s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel);
    end
    n_chk++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_master: got ack/err %b%b%b%b want 0000",
               m0_ack, m0_err, m1_ack, m1_err);
    end
    n_chk++;
    if (m0_dat !== 32'hA5A5_0F0F || m1_dat !== 32'hA5A5_0F0F) begin
      n_fail++;
      $display("FAIL reset_dat: got %h %h want a5a50f0f", m0_dat, m1_dat);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    m0_adr = 32'h100; m0_cyc = 1'b1; m0_stb = 1'b1;
    s_rdat = '0;
    smp();
    n_chk++;
    if (s_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: s_cyc got %b want 0", s_cyc);
    end
    nxt();
    smp();
    n_chk++;
    if ({s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel}
        !== {3'b110, 32'h100, 32'h0, 4'hF}) begin
      n_fail++;
      $display("FAIL single_bus: got %b%b%b %h %h %h want 110 100 0 f",
               s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel);
    end
    nxt();
    smp();
    n_chk++;
    if (m0_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL single_wait: m0_ack got %b want 0", m0_ack);
    end
    nxt();
    s_ack = 1'b1; s_rdat = 32'hDEADBEEF;
    smp();
    n_chk++;
    if ({m0_ack, m1_ack} !== 2'b10 || m0_dat !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_ack: got ack %b%b dat %h want 10 deadbeef",
               m0_ack, m1_ack, m0_dat);
    end
    nxt();
    idle_in();
    smp();
    n_chk++;
    if (s_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: s_cyc got %b want 0", s_cyc);
    end
    nxt();
  endtask

  task automatic test_simultaneous();
    do_reset();
    m0_adr = 32'h40; m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_adr = 32'h20; m1_wdat = 32'h12345678; m1_sel = 4'h3;
    m1_we = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    nxt();
    s_ack = 1'b1;
    smp();
    n_chk++;
    if ({s_cyc, s_we, s_adr, m0_ack, m1_ack} !== {2'b10, 32'h40, 2'b10}) begin
      n_fail++;
      $display("FAIL simul_first: got cyc %b we %b adr %h ack %b%b want M0",
               s_cyc, s_we, s_adr, m0_ack, m1_ack);
    end
    nxt();
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    nxt();
    smp();
    n_chk++;
    if ({s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel}
        !== {3'b111, 32'h20, 32'h12345678, 4'h3}) begin
      n_fail++;
      $display("FAIL simul_second: got %b%b%b %h %h %h want 111 20 12345678 3",
               s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel);
    end
    nxt();
    s_ack = 1'b1;
    smp();
    n_chk++;
    if ({m0_ack, m1_ack} !== 2'b01) begin
      n_fail++;
      $display("FAIL simul_ack: got %b%b want 01", m0_ack, m1_ack);
    end
    nxt();
    idle_in();
    nxt();
  endtask

  task automatic test_round_robin();
    int order[$];
    bit want[2];
    int wcnt, lat, cycles;
    do_reset();
    want[0] = 1'b1; want[1] = 1'b1;
    wcnt = 0; lat = $urandom_range(2, 0); cycles = 0;
    m0_adr = 32'h500; m1_adr = 32'h600; m1_we = 1'b0; m1_sel = 4'hF;
    while (order.size() < 8 && cycles < 200) begin
      m0_cyc = want[0]; m0_stb = want[0];
      m1_cyc = want[1]; m1_stb = want[1];
      #1;
      s_ack = s_stb && (wcnt >= lat);
      smp();
      if (m0_ack) order.push_back(0);
      if (m1_ack) order.push_back(1);
      for (int m = 0; m < 2; m++) begin
        if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) want[m] = 1'b0;
        else want[m] = 1'b1;
      end
      if (s_stb && !s_ack) wcnt++;
      else begin
        if (s_ack) lat = $urandom_range(2, 0);
        wcnt = 0;
      end
      cycles++;
      nxt();
    end
    n_chk++;
    if (order.size() < 8) begin
      n_fail++;
      $display("FAIL rr_count: got %0d transfers want 8", order.size());
    end
    for (int i = 0; i < order.size() && i < 8; i++) begin
      n_chk++;
      if (order[i] !== (i % 2)) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got M%0d want M%0d", i, order[i], i % 2);
      end
    end
    idle_in();
    nxt();
  endtask

  task automatic test_abort();
    do_reset();
    m1_adr = 32'h80; m1_we = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
    nxt();
    smp();
    n_chk++;
    if (s_cyc !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_grant: s_cyc got %b want 1", s_cyc);
    end
    nxt();
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b1;
    smp();
    n_chk++;
    if ({s_cyc, s_stb, m1_ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_drop: got cyc %b stb %b ack %b want 000",
               s_cyc, s_stb, m1_ack);
    end
    nxt();
    idle_in();
    nxt();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_adr = 32'h200; m0_cyc = 1'b1; m0_stb = 1'b1;
    nxt();
    smp();
    n_chk++;
    if (s_cyc !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_grant: s_cyc got %b want 1", s_cyc);
    end
    nxt();
    rst = 1'b1;
    nxt();
    s_ack = 1'b1;
    smp();
    n_chk++;
    if ({s_cyc, s_stb, m0_ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_bus: got cyc %b stb %b ack %b want 000",
               s_cyc, s_stb, m0_ack);
    end
    rst = 1'b0;
    idle_in();
    nxt();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int errs, err_at;
    logic cyc_at_err;
    do_reset();
    errs = 0; err_at = -1; cyc_at_err = 1'bx;
    m0_adr = 32'h300; m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp();
      if (m0_err) begin
        errs++;
        err_at = i;
        cyc_at_err = s_cyc;
      end
      nxt();
      if (errs > 0) begin
        m0_cyc = 1'b0; m0_stb = 1'b0;
      end
    end
    n_chk++;
    if (errs !== 1 || err_at !== 4) begin
      n_fail++;
      $display("FAIL timeout_pulse: got %0d pulses at %0d want 1 at 4",
               errs, err_at);
    end
    n_chk++;
    if (cyc_at_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_cyc: s_cyc got %b want 0", cyc_at_err);
    end
    idle_in();
    nxt();
  endtask
`else
  task automatic test_no_timeout();
    int bad_at;
    do_reset();
    bad_at = -1;
    m0_adr = 32'h300; m0_cyc = 1'b1; m0_stb = 1'b1;
    nxt();
    for (int i = 0; i < 300; i++) begin
      smp();
      if (bad_at < 0 && (m0_err !== 1'b0 || m1_err !== 1'b0 || s_stb !== 1'b1))
        bad_at = i;
      nxt();
    end
    n_chk++;
    if (bad_at >= 0) begin
      n_fail++;
      $display("FAIL no_timeout: got err/stb change at cycle %0d want none",
               bad_at);
    end
    idle_in();
    nxt();
  endtask
`endif

  task automatic test_random();
    int owner, last, wcnt;
    bit act[2];
    bit pc[2];
    logic [74:0] got, exp;
    do_reset();
    owner = -1; last = 1; wcnt = 0;
    act[0] = 1'b0; act[1] = 1'b0;
    pc[0] = 1'b0; pc[1] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      // Owner keeps the bus while holding cyc; otherwise a tie goes to
      // whoever was not granted most recently.
      if (!(owner >= 0 && pc[owner])) begin
        if (pc[0] && pc[1]) owner = 1 - last;
        else if (pc[0]) owner = 0;
        else if (pc[1]) owner = 1;
        else owner = -1;
      end
      if (owner >= 0) last = owner;
      for (int m = 0; m < 2; m++) begin
        if (!act[m] && $urandom_range(2, 0) == 0) begin
          act[m] = 1'b1;
          if (m == 0) m0_adr = $urandom;
          else begin
            m1_adr = $urandom; m1_wdat = $urandom;
            m1_sel = 4'($urandom); m1_we = 1'($urandom);
          end
        end else if (act[m] && $urandom_range(15, 0) == 0) begin
          act[m] = 1'b0;
        end
      end
      m0_cyc = act[0]; m0_stb = act[0];
      m1_cyc = act[1]; m1_stb = act[1];
      s_rdat = $urandom;
      #1;
      s_ack = s_stb && (wcnt >= 2 || $urandom_range(1, 0) == 1);
      smp();
      exp = '0;
      if (owner == 0)
        exp = {m0_cyc, m0_cyc & m0_stb, 1'b0, m0_adr, 32'h0, 4'hF,
               m0_cyc & s_ack, 1'b0, 2'b00};
      else if (owner == 1)
        exp = {m1_cyc, m1_cyc & m1_stb, m1_we, m1_adr, m1_wdat, m1_sel,
               1'b0, m1_cyc & s_ack, 2'b00};
      got = {s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel,
             m0_ack, m1_ack, m0_err, m1_err};
      n_chk++;
      if (got !== exp || m0_dat !== s_rdat || m1_dat !== s_rdat) begin
        n_fail++;
        $display("FAIL random[%0d] owner %0d: got %h want %h dat %h/%h want %h",
                 c, owner, got, exp, m0_dat, m1_dat, s_rdat);
      end
      if (m0_ack) act[0] = 1'b0;
      if (m1_ack) act[1] = 1'b0;
      if (s_stb && !s_ack) wcnt++;
      else wcnt = 0;
      pc[0] = m0_cyc; pc[1] = m1_cyc;
      nxt();
    end
    idle_in();
    nxt();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_abort();
    test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
